// File: rtl/motor_mv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_mv_pkg
// Description : Shared types and constants for the line-following motor
//               controller: FSM state encoding, motor direction codes,
//               parameter defaults and a small sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package motor_mv_pkg;

    // Parameter defaults used by motor_mv
    localparam int c_PWM_PERIOD_DEF   = 100;
    localparam int c_DUTY_FWD_DEF     = 60;
    localparam int c_DUTY_TURN_DEF    = 40;
    localparam int c_LOST_TIMEOUT_DEF = 1000;

    // Motor direction codes: {fwd, rev}
    localparam logic [1:0] c_DIR_FWD  = 2'b10;
    localparam logic [1:0] c_DIR_REV  = 2'b01;
    localparam logic [1:0] c_DIR_HALT = 2'b00;

    // Controller states
    typedef enum logic [2:0] {
        ST_STOP       = 3'd0,
        ST_FORWARD    = 3'd1,
        ST_TURN_LEFT  = 3'd2,
        ST_TURN_RIGHT = 3'd3,
        ST_SEARCH     = 3'd4,
        ST_LOST       = 3'd5
    } state_t;

    // Direction of the most recent turn, used to choose the search rotation
    typedef enum logic {
        LT_LEFT  = 1'b0,
        LT_RIGHT = 1'b1
    } turn_t;

    // Larger of two integers, used to size shared counters
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : motor_mv_pkg
`default_nettype wire

// File: rtl/motor_mv_pwm.sv
`default_nettype none
// ============================================================================
// Module      : motor_pwm
// Description : Free-running PWM counter (0..PWM_PERIOD-1) with a registered
//               comparator output. Output is high while counter < duty, so a
//               duty of PWM_PERIOD or more gives a constant high output.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_pwm #(
    parameter int PWM_PERIOD = 100,
    parameter int W          = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] duty,
    output logic         pwm
);

    logic [W-1:0] r_cnt_q;
    logic [W-1:0] w_cnt_d;
    logic         r_pwm_q;
    logic         w_pwm_d;

    // Next counter value (wraps at the period end) and comparator result
    always_comb begin
        w_cnt_d = (r_cnt_q == W'(PWM_PERIOD - 1)) ? '0 : (r_cnt_q + 1'b1);
        w_pwm_d = (r_cnt_q < duty);
    end

    // Counter and registered PWM output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_q <= '0;
            r_pwm_q <= 1'b0;
        end else begin
            r_cnt_q <= w_cnt_d;
            r_pwm_q <= w_pwm_d;
        end
    end

    assign pwm = r_pwm_q;

endmodule : motor_pwm
`default_nettype wire

// File: rtl/motor_mv.sv
`default_nettype none
// ============================================================================
// Module      : motor_mv
// Description : Line-following motor controller. Synchronizes the line and
//               obstacle sensors, runs a Moore FSM choosing between stop,
//               forward, turning, searching and lost, decodes motor
//               directions from the state and drives both PWM enables from a
//               shared duty value.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_mv
    import motor_mv_pkg::*;
#(
    parameter int PWM_PERIOD   = c_PWM_PERIOD_DEF,
    parameter int DUTY_FWD     = c_DUTY_FWD_DEF,
    parameter int DUTY_TURN    = c_DUTY_TURN_DEF,
    parameter int LOST_TIMEOUT = c_LOST_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] IPS,
    input  logic       midIPS,
    input  logic       IR,
    output logic [1:0] outDirectionL,
    output logic [1:0] outDirectionR,
    output logic [1:0] enable
);

    // Counters and duty share one width; +1 so the largest value itself fits
    localparam int c_MAX_VAL = max_of(max_of(PWM_PERIOD, DUTY_FWD),
                                      max_of(DUTY_TURN, LOST_TIMEOUT));
    localparam int c_W       = $clog2(c_MAX_VAL + 1);

    // Sensor vector layout: {IR, midIPS, IPS[1:0]}
    logic [3:0]     r_sync1_q;
    logic [3:0]     r_sync2_q;
    logic [3:0]     w_sync1_d;
    logic [3:0]     w_sync2_d;

    // The synchronizer holds stale zeros for two edges after reset; this
    // shift register marks when its second stage carries real sensor data.
    logic [1:0]     r_warm_q;
    logic [1:0]     w_warm_d;

    state_t         r_state_q;
    state_t         w_state_d;
    turn_t          r_last_turn_q;
    turn_t          w_last_turn_d;
    logic [c_W-1:0] r_search_cnt_q;
    logic [c_W-1:0] w_search_cnt_d;

    logic           w_ir;
    logic           w_mid;
    logic [1:0]     w_ips;
    logic [c_W-1:0] w_duty;
    logic           w_pwm;

    // Synchronizer and warm-up shift inputs
    always_comb begin
        w_sync1_d = {IR, midIPS, IPS};
        w_sync2_d = r_sync1_q;
        w_warm_d  = {r_warm_q[0], 1'b1};
    end

    // Two-flop synchronizer and warm-up tracker
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1_q <= '0;
            r_sync2_q <= '0;
            r_warm_q  <= '0;
        end else begin
            r_sync1_q <= w_sync1_d;
            r_sync2_q <= w_sync2_d;
            r_warm_q  <= w_warm_d;
        end
    end

    assign w_ir  = r_sync2_q[3];
    assign w_mid = r_sync2_q[2];
    assign w_ips = r_sync2_q[1:0];

    // Next-state rules in priority order; first match wins
    always_comb begin
        w_state_d = r_state_q;
        if (!r_warm_q[1]) begin
            w_state_d = ST_STOP;
        end else if (w_ir) begin
            w_state_d = ST_STOP;
        end else if (w_ips == 2'b11) begin
            w_state_d = ST_FORWARD;
        end else if (w_ips == 2'b10) begin
            w_state_d = ST_TURN_LEFT;
        end else if (w_ips == 2'b01) begin
            w_state_d = ST_TURN_RIGHT;
        end else if (w_mid) begin
            w_state_d = ST_FORWARD;
        end else if (r_state_q == ST_LOST) begin
            w_state_d = ST_LOST;
        end else if ((r_state_q == ST_SEARCH) &&
                     (r_search_cnt_q == c_W'(LOST_TIMEOUT - 1))) begin
            w_state_d = ST_LOST;
        end else begin
            w_state_d = ST_SEARCH;
        end
    end

    // Search timer restarts at zero on SEARCH entry and saturates at the limit
    always_comb begin
        w_search_cnt_d = '0;
        if ((w_state_d == ST_SEARCH) && (r_state_q == ST_SEARCH)) begin
            if (r_search_cnt_q == c_W'(LOST_TIMEOUT - 1)) begin
                w_search_cnt_d = r_search_cnt_q;
            end else begin
                w_search_cnt_d = r_search_cnt_q + 1'b1;
            end
        end
    end

    // Remember which way the robot last turned
    always_comb begin
        w_last_turn_d = r_last_turn_q;
        if (w_state_d == ST_TURN_LEFT) begin
            w_last_turn_d = LT_LEFT;
        end else if (w_state_d == ST_TURN_RIGHT) begin
            w_last_turn_d = LT_RIGHT;
        end
    end

    // State, search timer and last-turn registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= ST_STOP;
            r_search_cnt_q <= '0;
            r_last_turn_q  <= LT_LEFT;
        end else begin
            r_state_q      <= w_state_d;
            r_search_cnt_q <= w_search_cnt_d;
            r_last_turn_q  <= w_last_turn_d;
        end
    end

    // Duty follows the state being entered so enables change with directions
    always_comb begin
        w_duty = '0;
        unique case (w_state_d)
            ST_FORWARD:                           w_duty = c_W'(DUTY_FWD);
            ST_TURN_LEFT, ST_TURN_RIGHT,
            ST_SEARCH:                            w_duty = c_W'(DUTY_TURN);
            default:                              w_duty = '0;
        endcase
    end

    // Motor directions decoded from the registered state
    always_comb begin
        outDirectionL = c_DIR_HALT;
        outDirectionR = c_DIR_HALT;
        unique case (r_state_q)
            ST_FORWARD: begin
                outDirectionL = c_DIR_FWD;
                outDirectionR = c_DIR_FWD;
            end
            ST_TURN_LEFT: begin
                outDirectionL = c_DIR_REV;
                outDirectionR = c_DIR_FWD;
            end
            ST_TURN_RIGHT: begin
                outDirectionL = c_DIR_FWD;
                outDirectionR = c_DIR_REV;
            end
            ST_SEARCH: begin
                if (r_last_turn_q == LT_LEFT) begin
                    outDirectionL = c_DIR_REV;
                    outDirectionR = c_DIR_FWD;
                end else begin
                    outDirectionL = c_DIR_FWD;
                    outDirectionR = c_DIR_REV;
                end
            end
            default: begin
                outDirectionL = c_DIR_HALT;
                outDirectionR = c_DIR_HALT;
            end
        endcase
    end

    motor_pwm #(
        .PWM_PERIOD (PWM_PERIOD),
        .W          (c_W)
    ) u_pwm (
        .clk   (clk),
        .reset (reset),
        .duty  (w_duty),
        .pwm   (w_pwm)
    );

    // Both wheels share one duty; steering comes from direction only
    assign enable = {w_pwm, w_pwm};

endmodule : motor_mv
`default_nettype wire

// File: tb/tb_motor_mv.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_mv
// Description : Self-checking bench for motor_mv. A cycle-level reference
//               model built from the behavioural rules (input history queue,
//               edge counts, duty table) predicts directions and enables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_mv;

    localparam int P  = 100;
    localparam int DF = 60;
    localparam int DT = 40;
    localparam int TO = 1000;

    localparam int M_STOP = 0, M_FWD = 1, M_TL = 2, M_TR = 3, M_SEARCH = 4, M_LOST = 5;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] IPS    = 2'b00;
    logic       midIPS = 1'b0;
    logic       IR     = 1'b0;
    logic [1:0] outDirectionL;
    logic [1:0] outDirectionR;
    logic [1:0] enable;

    motor_mv #(
        .PWM_PERIOD   (P),
        .DUTY_FWD     (DF),
        .DUTY_TURN    (DT),
        .LOST_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .IPS           (IPS),
        .midIPS        (midIPS),
        .IR            (IR),
        .outDirectionL (outDirectionL),
        .outDirectionR (outDirectionR),
        .enable        (enable)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_state = M_STOP;
    int         m_last  = 0;      // 0 left, 1 right
    int         m_age   = 0;      // edges already spent in SEARCH
    int         m_n     = 0;      // edges since reset release
    logic [1:0] m_en    = 2'b00;
    logic [3:0] m_log[$];         // {ir, mid, ips} applied at each edge since release

    function automatic int duty_of(input int s);
        if (s == M_FWD) return DF;
        if (s == M_TL || s == M_TR || s == M_SEARCH) return DT;
        return 0;
    endfunction

    // Expected {L, R, enable}
    function automatic logic [5:0] m_expect();
        logic [3:0] lr;
        case (m_state)
            M_FWD:    lr = 4'b1010;
            M_TL:     lr = 4'b0110;
            M_TR:     lr = 4'b1001;
            M_SEARCH: lr = (m_last == 0) ? 4'b0110 : 4'b1001;
            default:  lr = 4'b0000;
        endcase
        return {lr, m_en};
    endfunction

    // Advance the model by one rising edge with the given inputs present
    task automatic model_edge(input logic [1:0] ips, input logic mid, input logic ir,
                              input logic rst);
        int         nxt;
        logic [3:0] s;
        if (rst) begin
            m_state = M_STOP;
            m_last  = 0;
            m_age   = 0;
            m_n     = 0;
            m_en    = 2'b00;
            m_log.delete();
        end else begin
            nxt = M_STOP;
            if (m_n >= 2) begin
                s = m_log[m_n - 2];
                if (s[3])                 nxt = M_STOP;
                else if (s[1:0] == 2'b11) nxt = M_FWD;
                else if (s[1:0] == 2'b10) nxt = M_TL;
                else if (s[1:0] == 2'b01) nxt = M_TR;
                else if (s[2])            nxt = M_FWD;
                else if (m_state == M_LOST) nxt = M_LOST;
                else if (m_state == M_SEARCH && m_age == TO - 1) nxt = M_LOST;
                else nxt = M_SEARCH;
            end
            m_en  = ((m_n % P) < duty_of(nxt)) ? 2'b11 : 2'b00;
            m_age = (nxt == M_SEARCH && m_state == M_SEARCH) ? m_age + 1 : 0;
            if (nxt == M_TL) m_last = 0;
            if (nxt == M_TR) m_last = 1;
            m_state = nxt;
            m_log.push_back({ir, mid, ips});
            m_n++;
        end
    endtask

    // Apply inputs for one clock, update the model, then settle past the edge
    task automatic cycle(input logic [1:0] ips, input logic mid, input logic ir,
                         input logic rst);
        IPS    = ips;
        midIPS = mid;
        IR     = ir;
        reset  = rst;
        @(posedge clk);
        model_edge(ips, mid, ir, rst);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        for (int i = 0; i < 3; i++) begin
            cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
        got = {outDirectionL, outDirectionR, enable};
        n_tests++;
        if (got !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=000000", got);
        end
        n_tests++;
        if (dut.u_pwm.r_cnt_q !== '0) begin
            n_fail++;
            $display("FAIL reset_pwm_cnt got=%0d exp=0", dut.u_pwm.r_cnt_q);
        end
        // Release with forward inputs: STOP for two edges, FORWARD on the third
        for (int i = 0; i < 3; i++) begin
            cycle(2'b00, 1'b1, 1'b0, 1'b0);
            got = {outDirectionL, outDirectionR, enable};
            n_tests++;
            if (got !== m_expect()) begin
                n_fail++;
                $display("FAIL reset_release edge=%0d got=%b exp=%b", i, got, m_expect());
            end
        end
        n_tests++;
        if ({outDirectionL, outDirectionR} !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_first_fwd got=%b exp=1010", {outDirectionL, outDirectionR});
        end
    endtask

    task automatic test_forward_duty();
        logic [5:0] got;
        int         highs;
        highs = 0;
        for (int i = 0; i < 250; i++) begin
            cycle(2'b00, 1'b1, 1'b0, 1'b0);
            got = {outDirectionL, outDirectionR, enable};
            n_tests++;
            if (got !== m_expect()) begin
                n_fail++;
                $display("FAIL fwd_cycle i=%0d got=%b exp=%b", i, got, m_expect());
            end
            if (i >= 100 && i < 200 && enable == 2'b11) highs++;
        end
        n_tests++;
        if (highs != DF) begin
            n_fail++;
            $display("FAIL fwd_duty got=%0d exp=%0d", highs, DF);
        end
    endtask

    task automatic test_turns();
        logic [5:0] got;
        int         highs;
        highs = 0;
        for (int i = 0; i < 150; i++) begin
            cycle(2'b10, 1'b1, 1'b0, 1'b0);
            got = {outDirectionL, outDirectionR, enable};
            n_tests++;
            if (got !== m_expect()) begin
                n_fail++;
                $display("FAIL turn_left_cycle i=%0d got=%b exp=%b", i, got, m_expect());
            end
            if (i >= 50 && enable == 2'b11) highs++;
        end
        n_tests++;
        if ({outDirectionL, outDirectionR} !== 4'b0110) begin
            n_fail++;
            $display("FAIL turn_left_dir got=%b exp=0110", {outDirectionL, outDirectionR});
        end
        n_tests++;
        if (highs != DT) begin
            n_fail++;
            $display("FAIL turn_duty got=%0d exp=%0d", highs, DT);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(2'b01, 1'b1, 1'b0, 1'b0);
            got = {outDirectionL, outDirectionR, enable};
            n_tests++;
            if (got !== m_expect()) begin
                n_fail++;
                $display("FAIL turn_right_cycle i=%0d got=%b exp=%b", i, got, m_expect());
            end
        end
        n_tests++;
        if ({outDirectionL, outDirectionR} !== 4'b1001) begin
            n_fail++;
            $display("FAIL turn_right_dir got=%b exp=1001", {outDirectionL, outDirectionR});
        end
    endtask

    task automatic test_search_lost();
        logic [5:0] got;
        for (int i = 0; i < 5; i++) cycle(2'b10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1010; i++) begin
            cycle(2'b00, 1'b0, 1'b0, 1'b0);
            got = {outDirectionL, outDirectionR, enable};
            n_tests++;
            if (got !== m_expect()) begin
                n_fail++;
                $display("FAIL search_cycle i=%0d got=%b exp=%b", i, got, m_expect());
            end
            if (i == 2 || i == 1001) begin
                n_tests++;
                if ({outDirectionL, outDirectionR} !== 4'b0110) begin
                    n_fail++;
                    $display("FAIL search_dir i=%0d got=%b exp=0110", i,
                             {outDirectionL, outDirectionR});
                end
            end
        end
        n_tests++;
        if (got !== 6'b000000) begin
            n_fail++;
            $display("FAIL lost_outputs got=%b exp=000000", got);
        end
        // Only rules 1-4 leave LOST
        for (int i = 0; i < 4; i++) begin
            cycle(2'b00, 1'b1, 1'b0, 1'b0);
            got = {outDirectionL, outDirectionR, enable};
            n_tests++;
            if (got !== m_expect()) begin
                n_fail++;
                $display("FAIL lost_exit i=%0d got=%b exp=%b", i, got, m_expect());
            end
        end
    endtask

    task automatic test_obstacle();
        logic [5:0] got;
        for (int i = 0; i < 5; i++) cycle(2'b01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0);
        got = {outDirectionL, outDirectionR, enable};
        n_tests++;
        if (got !== 6'b000000) begin
            n_fail++;
            $display("FAIL obstacle_stop got=%b exp=000000", got);
        end
        for (int i = 0; i < 3; i++) cycle(2'b11, 1'b0, 1'b0, 1'b0);
        got = {outDirectionL, outDirectionR, enable};
        n_tests++;
        if (got[5:2] !== 4'b1010 || got !== m_expect()) begin
            n_fail++;
            $display("FAIL obstacle_crossing got=%b exp=%b", got, m_expect());
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] got;
        for (int i = 0; i < 5; i++) cycle(2'b01, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if ({outDirectionL, outDirectionR} !== 4'b1001) begin
            n_fail++;
            $display("FAIL reset_mid_pre got=%b exp=1001", {outDirectionL, outDirectionR});
        end
        cycle(2'b01, 1'b1, 1'b0, 1'b1);
        got = {outDirectionL, outDirectionR, enable};
        n_tests++;
        if (got !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got=%b exp=000000", got);
        end
        n_tests++;
        if (dut.u_pwm.r_cnt_q !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_pwm_cnt got=%0d exp=0", dut.u_pwm.r_cnt_q);
        end
    endtask

    task automatic test_random();
        logic [5:0] got;
        logic [1:0] ips;
        logic       mid;
        logic       ir;
        int         len;
        int         done;
        done = 0;
        while (done < 1500) begin
            ips = 2'($urandom_range(0, 3));
            mid = 1'($urandom_range(0, 1));
            ir  = ($urandom_range(0, 5) == 0);
            len = $urandom_range(1, 25);
            for (int k = 0; k < len; k++) begin
                cycle(ips, mid, ir, ($urandom_range(0, 59) == 0));
                got = {outDirectionL, outDirectionR, enable};
                n_tests++;
                if (got !== m_expect()) begin
                    n_fail++;
                    $display("FAIL random_cycle n=%0d got=%b exp=%b", done, got, m_expect());
                end
                done++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward_duty();
        test_turns();
        test_search_lost();
        test_obstacle();
        test_reset_mid();
        cycle(2'b00, 1'b0, 1'b0, 1'b0);
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_motor_mv
`default_nettype wire

// File: doc/motor_mv.md
MOTOR_MV -- requirements
Module: motor_mv

Interface
REQ-001 SHALL declare parameters (name, default, meaning): PWM_PERIOD, 100, PWM counter period in clocks.
REQ-002 SHALL declare: DUTY_FWD, 60, high clocks per period for FORWARD.
REQ-003 SHALL declare: DUTY_TURN, 40, high clocks per period for turn and search states.
REQ-004 SHALL declare: LOST_TIMEOUT, 1000, clocks in SEARCH before stopping.
REQ-005 SHALL have port: clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port: IPS  input  2  line sensors; bit1 left, bit0 right; 1 = line detected.
REQ-008 SHALL have port: midIPS  input  1  centre line sensor; 1 = line detected.
REQ-009 SHALL have port: IR  input  1  obstacle sensor; 1 = obstacle present.
REQ-010 SHALL have port: outDirectionL  output  2  left motor direction; 10 forward, 01 reverse, 00 stop.
REQ-011 SHALL have port: outDirectionR  output  2  right motor direction; same encoding.
REQ-012 SHALL have port: enable  output  2  PWM enables; bit1 left, bit0 right.

Function
REQ-013 SHALL pass IPS, midIPS and IR through a two-flop synchronizer before any use.
REQ-014 SHALL implement a Moore FSM with states STOP, FORWARD, TURN_LEFT, TURN_RIGHT, SEARCH, LOST.
REQ-015 SHALL evaluate next state from synchronized inputs in priority order; the first matching rule wins.
REQ-016 Rule 1: IR=1 -> STOP.
REQ-017 Rule 2: IPS=11 -> FORWARD (crossing).
REQ-018 Rule 3: IPS=10 -> TURN_LEFT; IPS=01 -> TURN_RIGHT.
REQ-019 Rule 4: IPS=00 and midIPS=1 -> FORWARD.
REQ-020 Rule 5: IPS=00, midIPS=0 -> SEARCH, from FORWARD, TURN_*, STOP or SEARCH.
REQ-021 From LOST, Rule 5 SHALL keep LOST; only rules 1-4 exit LOST.
REQ-022 SEARCH SHALL count clocks from 0 on entry; at count LOST_TIMEOUT-1 with Rule 5 still true, next state SHALL be LOST.
REQ-023 A last_turn register SHALL record left/right on entry to TURN_LEFT/TURN_RIGHT; SEARCH rotates in that direction.
REQ-024 Direction decode, L/R: STOP 00/00; FORWARD 10/10; TURN_LEFT 01/10; TURN_RIGHT 10/01; SEARCH as the turn matching last_turn; LOST 00/00.
REQ-025 Direction outputs SHALL be decoded from the state register only.
REQ-026 Latency: an input change before edge k SHALL change direction outputs after edge k+2 (2 sync edges + 1 state edge).
REQ-027 Duty SHALL be DUTY_FWD in FORWARD, DUTY_TURN in TURN_*/SEARCH, and 0 in STOP/LOST.
REQ-028 A free-running PWM counter SHALL count 0..PWM_PERIOD-1 and wrap to 0.
REQ-029 Each enable bit SHALL be registered as (counter < duty); duty >= PWM_PERIOD gives constant 1.
REQ-030 Both enable bits SHALL use the same duty; differential drive comes from direction only.
REQ-031 Counter and duty widths SHALL be $clog2 of the largest parameter value; the search counter SHALL never wrap past LOST_TIMEOUT.

Reset
REQ-032 On reset=1 at a rising edge: state=STOP, outDirectionL=outDirectionR=00, enable=00.
REQ-033 On reset=1 at a rising edge: PWM and search counters=0, synchronizer flops=0, last_turn=left.
REQ-034 Reset asserted mid-operation, including in SEARCH or LOST, SHALL take effect at the next edge and override all inputs.
REQ-035 After release, the first non-STOP state SHALL appear no earlier than 3 edges later.

Structure
REQ-036 A shared package SHALL hold the state enum, the direction encodings (FWD=10, REV=01, HALT=00) and the parameter defaults.
REQ-037 PWM counter and comparator SHALL be one sub-module, motor_pwm (inputs duty and clk/reset; output 1-bit pwm); the FSM stays in motor_mv.

Verification
REQ-038 Reset, then midIPS=1, IPS=00, IR=0 -> after 3 edges L=R=10; enable high 60 of every 100 clocks.
REQ-039 midIPS=1, IPS=10 -> L=01, R=10, 40% duty; then IPS=01 -> L=10, R=01.
REQ-040 IPS=10 followed by midIPS=0, IPS=00 -> SEARCH, L=01, R=10; after 1000 clocks -> LOST, L=R=00, enable=00.
REQ-041 From any moving state, IR=1 -> L=R=00, enable=00 within 3 edges; IR=0 with IPS=11 -> FORWARD.
REQ-042 Assert reset=1 during TURN_RIGHT -> next edge L=R=00, enable=00, PWM counter 0.
